// File: rtl/spi_resp_tx_if.sv
// Bundle of the chip-select, load and status signals around the SPI response transmitter.
// The master side is the game logic / MCU model; the slave side is the transmitter.
interface spi_resp_tx_if #(
    parameter int NBYTES = 2
);
    logic                  cs;
    logic                  load;
    logic [8*NBYTES-1:0]   din;
    logic                  sdo;
    logic                  armed;
    logic                  busy;
    logic                  sent;
    logic                  overrun;

    modport master (
        output cs, load, din,
        input  sdo, armed, busy, sent, overrun
    );

    modport slave (
        input  cs, load, din,
        output sdo, armed, busy, sent, overrun
    );
endinterface

// File: rtl/spi_resp_tx.sv
// SPI mode-1 peripheral transmitter: frames a buffered payload as HEADER, payload, XOR checksum
// and shifts it MSB-first on sdo during a cs-low window, all on rising sck.
module spi_resp_tx #(
    parameter int          NBYTES = 2,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic           sck,
    input  logic           reset,
    spi_resp_tx_if.slave   bus
);
    localparam int PAY_W      = 8 * NBYTES;
    localparam int FRAME_BITS = 8 * (NBYTES + 2);
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [PAY_W-1:0]   buf_q, buf_d;
    logic [7:0]         chk_q, chk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sdo_q, sdo_d;
    logic               armed_q, armed_d;
    logic               busy_q, busy_d;
    logic               sent_q, sent_d;
    logic               overrun_q, overrun_d;

    logic [FRAME_BITS-1:0] frame;
    logic [CNT_W-1:0]      cnt_nxt;

    function automatic logic [7:0] xor_bytes(input logic [PAY_W-1:0] p);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            acc = acc ^ p[8*i +: 8];
        end
        return acc;
    endfunction

    // Frame bit k lives at index LAST-k, so bit 0 is HEADER[7].
    assign frame   = {HEADER, buf_q, chk_q};
    assign cnt_nxt = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        chk_d     = chk_q;
        cnt_d     = cnt_q;
        sdo_d     = 1'b0;
        sent_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    if (bus.cs) begin
                        buf_d   = bus.din;
                        chk_d   = xor_bytes(bus.din);
                        state_d = ST_ARMED;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (bus.load) begin
                    if (bus.cs) begin
                        buf_d = bus.din;
                        chk_d = xor_bytes(bus.din);
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                if (!bus.cs) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sdo_d   = frame[LAST];
                end
            end
            ST_SHIFT: begin
                if (bus.load) begin
                    overrun_d = 1'b1;
                end
                if (bus.cs) begin
                    // Aborted window: keep the buffer so the next window restarts the frame.
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_nxt;
                    sdo_d = frame[LAST - cnt_nxt];
                    if (cnt_nxt == LAST) begin
                        state_d = ST_IDLE;
                        sent_d  = 1'b1;
                        buf_d   = '0;
                        chk_d   = 8'h00;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        armed_d = (state_d == ST_ARMED);
        busy_d  = (state_d == ST_SHIFT);
    end

    always_ff @(posedge sck) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            chk_q     <= 8'h00;
            cnt_q     <= '0;
            sdo_q     <= 1'b0;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            chk_q     <= chk_d;
            cnt_q     <= cnt_d;
            sdo_q     <= sdo_d;
            armed_q   <= armed_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.sdo     = sdo_q;
    assign bus.armed   = armed_q;
    assign bus.busy    = busy_q;
    assign bus.sent    = sent_q;
    assign bus.overrun = overrun_q;
endmodule
